// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ula_seq_unit EX-stage execution unit.
//   - ula_operation codes and R-type func codes
//   - FSM state encoding and the request classification helper
// Configuration macro: ULA_DIV_EN (when undefined, div/divu decode as illegal).
package ula_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_RTYPE   = 3'b010;
    localparam logic [2:0] OP_SLTI    = 3'b011;
    localparam logic [2:0] OP_ANDI    = 3'b100;
    localparam logic [2:0] OP_ORI     = 3'b101;
    localparam logic [2:0] OP_XORI    = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC1 = 3'd1,
        MUL   = 3'd2,
        DIV   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_SINGLE = 2'd0,
        K_MUL    = 2'd1,
        K_DIV    = 2'd2
    } kind_t;

    // Which path a request takes. Without the divider, div/divu stay on the
    // single-cycle path where the decoder flags them as illegal.
    function automatic kind_t op_kind(input logic [2:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_SINGLE;
        if (op == OP_RTYPE) begin
            if (fn == F_MULT || fn == F_MULTU) begin
                k = K_MUL;
            end
`ifdef ULA_DIV_EN
            if (fn == F_DIV || fn == F_DIVU) begin
                k = K_DIV;
            end
`endif
        end
        return k;
    endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter: iterative multiply / divide engine, one bit per cycle.
//   clk, reset      clock, async active-high reset
//   start           load operands and begin WIDTH iterations
//   mode            0 = multiply, 1 = divide (ignored unless ULA_DIV_EN)
//   sgn             operands are two's complement
//   a, b            multiplier/dividend, multiplicand/divisor
//   done            one-cycle pulse the cycle after the final iteration
//   hi, lo          sign-corrected result halves (valid while done is high)
// Configuration macro: ULA_DIV_EN adds the restoring divider datapath.
module ula_muldiv_iter
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic               neg_res;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign prod    = neg_res ? -acc : acc;

`ifdef ULA_DIV_EN
    logic               mode_r;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   a_save;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
    assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
    assign quo   = acc[WIDTH-1:0];
    assign rem   = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        acc_next = acc;
        if (mode_r) begin
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
        if (mode_r) begin
            if (div_zero) begin
                hi = a_save;
                lo = '1;
            end else begin
                hi = neg_rem ? -rem : rem;
                lo = neg_res ? -quo : quo;
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    assign acc_next = {mul_sum, acc[WIDTH-1:1]};
    assign hi       = prod[2*WIDTH-1:WIDTH];
    assign lo       = prod[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            operand <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg_res <= 1'b0;
`ifdef ULA_DIV_EN
            mode_r   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_save   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                operand <= b_mag;
                cnt     <= CNT_W'(WIDTH);
                busy    <= 1'b1;
                neg_res <= a_neg ^ b_neg;
`ifdef ULA_DIV_EN
                mode_r   <= mode;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
                a_save   <= a;
`endif
            end else if (busy) begin
                acc <= acc_next;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ula_seq_unit.sv
// ula_seq_unit: EX-stage execution unit of the multicycle MIPS datapath.
// Decodes ula_operation/func, runs single-cycle ops in one registered cycle
// and mult/div iteratively into internal HI/LO registers.
//   clk, reset               clock, async active-high reset
//   in_valid / in_ready      request handshake (a, b, ula_operation, func)
//   out_valid / out_ready    result handshake (result, zero, overflow, err)
// Configuration macro: ULA_DIV_EN enables div/divu; otherwise they are illegal.
//
// state | meaning
// IDLE  | ready for a request
// EXEC1 | evaluating a single-cycle op on the captured operands
// MUL   | multiplier iterating
// DIV   | divider iterating
// DONE  | result presented, waiting for out_ready
module ula_seq_unit
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ula_operation,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);

    state_t state;
    state_t state_next;
    kind_t  req_kind;

    logic [2:0]       op_r;
    logic [5:0]       func_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             accept;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic                    add_ov;
    logic                    sub_ov;
    logic                    lt_s;
    logic                    lt_u;
    logic [SH_W-1:0]         sh;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        sra_res;

    logic [WIDTH-1:0] sc_res;
    logic             sc_ov;
    logic             sc_err;
    logic             hi_we;
    logic             lo_we;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign req_kind  = op_kind(ula_operation, func);
    assign eng_start = accept && (req_kind != K_SINGLE);

    ula_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .mode  (req_kind == K_DIV),
        .sgn   ((func == F_MULT) || (func == F_DIV)),
        .a     (a),
        .b     (b),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    assign sum     = a_r + b_r;
    assign diff    = a_r - b_r;
    assign add_ov  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
    assign sub_ov  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
    assign lt_s    = $signed(a_r) < $signed(b_r);
    assign lt_u    = a_r < b_r;
    assign sh      = a_r[SH_W-1:0];
    assign b_s     = b_r;
    assign sra_res = b_s >>> sh;

    always_comb begin
        sc_res = '0;
        sc_ov  = 1'b0;
        sc_err = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        case (op_r)
            OP_ADD: begin
                sc_res = sum;
                sc_ov  = add_ov;
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ov  = sub_ov;
            end
            OP_SLTI: sc_res = WIDTH'(lt_s);
            OP_ANDI: sc_res = a_r & b_r;
            OP_ORI:  sc_res = a_r | b_r;
            OP_XORI: sc_res = a_r ^ b_r;
            OP_RTYPE: begin
                case (func_r)
                    F_ADD: begin
                        sc_res = sum;
                        sc_ov  = add_ov;
                    end
                    F_ADDU: sc_res = sum;
                    F_SUB: begin
                        sc_res = diff;
                        sc_ov  = sub_ov;
                    end
                    F_SUBU: sc_res = diff;
                    F_AND:  sc_res = a_r & b_r;
                    F_OR:   sc_res = a_r | b_r;
                    F_XOR:  sc_res = a_r ^ b_r;
                    F_NOR:  sc_res = ~(a_r | b_r);
                    F_SLT:  sc_res = WIDTH'(lt_s);
                    F_SLTU: sc_res = WIDTH'(lt_u);
                    F_SLLV: sc_res = b_r << sh;
                    F_SRLV: sc_res = b_r >> sh;
                    F_SRAV: sc_res = sra_res;
                    F_MFHI: sc_res = hi;
                    F_MFLO: sc_res = lo;
                    F_MTHI: begin
                        sc_res = a_r;
                        hi_we  = 1'b1;
                    end
                    F_MTLO: begin
                        sc_res = a_r;
                        lo_we  = 1'b1;
                    end
`ifndef ULA_DIV_EN
                    F_DIV, F_DIVU: sc_err = 1'b1;
`endif
                    default: sc_err = 1'b1;
                endcase
            end
            default: sc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (req_kind)
                        K_MUL:   state_next = MUL;
                        K_DIV:   state_next = DIV;
                        default: state_next = EXEC1;
                    endcase
                end
            end
            EXEC1:    state_next = DONE;
            MUL, DIV: if (eng_done) state_next = DONE;
            DONE:     if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= '0;
            func_r   <= '0;
            a_r      <= '0;
            b_r      <= '0;
            hi       <= '0;
            lo       <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= ula_operation;
                        func_r <= func;
                        a_r    <= a;
                        b_r    <= b;
                    end
                end
                EXEC1: begin
                    result   <= sc_res;
                    zero     <= (sc_res == '0);
                    overflow <= sc_ov;
                    err      <= sc_err;
                    if (hi_we) hi <= a_r;
                    if (lo_we) lo <= a_r;
                end
                MUL, DIV: begin
                    if (eng_done) begin
                        hi       <= eng_hi;
                        lo       <= eng_lo;
                        result   <= eng_lo;
                        zero     <= (eng_lo == '0);
                        overflow <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ula_seq_unit.md
Name: ula_seq_unit

Overview:
- Parametrised successor to the ALU control decoder: decodes ula_operation/func itself and executes the operation.
- Single-cycle ops complete in one registered cycle; MULT/MULTU/DIV/DIVU run iteratively into internal HI/LO registers.
- Sits in the EX stage of the multicycle MIPS datapath.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, >= 8.
- SH_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- ula_operation  in  3  000 add, 001 sub, 010 R-type, 011 slti, 100 andi, 101 ori, 110 xori, 111 illegal
- func  in  6  R-type function field
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand or extended immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (add, sub only)
- err  out  1  illegal ula_operation/func

Behaviour:
- Reset (async): state IDLE; result, HI, LO = 0; out_valid, zero, overflow, err = 0.
- in_ready = (state == IDLE). Request is accepted on in_valid && in_ready; a, b, ula_operation and func are captured on acceptance.
- FSM: IDLE -> EXEC1 (single-cycle op) | MUL | DIV.
  - EXEC1 -> DONE next cycle.
  - MUL/DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE when out_ready. out_valid = (state == DONE); result and flags are held stable while out_ready is low.
- Latency from acceptance to out_valid: 2 cycles for single-cycle ops; WIDTH+2 cycles for mult/div.
- R-type func codes:
  - 100000 add (overflow flag), 100001 addu, 100010 sub (overflow flag), 100011 subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed), 101011 sltu (unsigned).
  - 000100 sllv: b << a[SH_W-1:0]. 000110 srlv: logical. 000111 srav: arithmetic.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - 010000 mfhi, 010010 mflo: result = HI/LO, single-cycle.
  - 010001 mthi, 010011 mtlo: HI/LO = a; result = a.
  - Any other func: err=1, result=0; HI/LO unchanged.
- slti is a signed compare; andi, ori and xori operate bitwise on b.
- Mult: shift-add on magnitudes, one bit per cycle. Signed variants negate the 2*WIDTH product if operand signs differ. HI = upper half, LO = lower half. result = LO.
- Div: restoring division, one bit per cycle. LO = quotient, HI = remainder. Remainder sign follows the dividend. result = LO.
- Divide by zero: LO = all ones, HI = a; err=0. Completes in the normal WIDTH+2 latency.
- Signed edge cases:
  - DIV of most-negative by -1: LO = most-negative, HI = 0, no trap.
  - MULT of most-negative by most-negative: HI = 2^(WIDTH-2), LO = 0.
- zero is computed from the final result; overflow is 0 for every op except add/sub.
- Reset asserted mid-iteration aborts the operation: HI/LO = 0, state IDLE.

Optional Feature:
- ULA_DIV_EN defined: divider datapath and DIV state are present, as above.
- ULA_DIV_EN undefined: func 011010/011011 behave as illegal (err=1, result=0, 2-cycle latency, HI/LO unchanged); no divider logic is synthesised.

Decomposition:
- Package ula_pkg: func code localparams, ula_operation codes, FSM state encoding (IDLE, EXEC1, MUL, DIV, DONE).
- Sub-module ula_muldiv_iter: iterative mult/div engine with start/done, signed flag, mode; owns the iteration counter and the 2*WIDTH accumulator.

Test Plan:
- add with a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, out_valid 2 cycles after accept. addu with the same operands -> overflow=0.
- srav with a=4, b=0x80000000 -> 0xF8000000. srlv with the same operands -> 0x08000000. sltu with a=1, b=0xFFFFFFFF -> 1; slt with the same operands -> 0.
- mult with a=-3, b=7, then mfhi/mflo -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. mult out_valid exactly 34 cycles after accept; in_ready=0 throughout.
- div with a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. New request accepted only the cycle after the out_ready handshake.
- Assert reset at iteration 10 of multu -> all outputs 0 immediately; mflo after release returns 0.
